// File: rtl/axo_mem_copier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axo_copier_pkg
//  Description : Shared constants for the axo_mem word copier: FSM state
//                encodings and the AXO_MEM_* bus error codes.
//  Revision    : 1.0  initial release
// ============================================================================
package axo_copier_pkg;

    // Copier FSM states
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;
    localparam logic [2:0] S_ABORT = 3'd5;

    // axo_mem bus status codes, returned on rdata alongside error=1
    localparam logic [31:0] AXO_MEM_OK       = 32'h0000_0000;
    localparam logic [31:0] AXO_MEM_EADDR    = 32'h0000_0001;
    localparam logic [31:0] AXO_MEM_READONLY = 32'h0000_0002;
    localparam logic [31:0] AXO_MEM_EALIGN   = 32'h0000_0003;

    // asize encoding for a full 32-bit word beat
    localparam logic [1:0]  C_ASIZE_WORD     = 2'd2;

endpackage : axo_copier_pkg
`default_nettype wire

// File: rtl/axo_mem_copier_if.sv
`default_nettype none
// ============================================================================
//  Module      : axo_mem_bus
//  Description : axo_mem bus interface. The initiator drives the request
//                (re/we/asize/addr/wdata); the responder returns rdata,
//                ready and error.
//  Revision    : 1.0  initial release
// ============================================================================
interface axo_mem_bus #(
    parameter int ALEN = 32,
    parameter int DLEN = 32
);
    logic            re;
    logic            we;
    logic [1:0]      asize;
    logic [ALEN-1:0] addr;
    logic [DLEN-1:0] wdata;
    logic [DLEN-1:0] rdata;
    logic            ready;
    logic            error;

    modport master (
        output re, we, asize, addr, wdata,
        input  rdata, ready, error
    );

    modport slave (
        input  re, we, asize, addr, wdata,
        output rdata, ready, error
    );
endinterface : axo_mem_bus
`default_nettype wire

// File: rtl/axo_mem_copier.sv
`default_nettype none
// ============================================================================
//  Module      : axo_mem_copier
//  Description : DMA-style word copier on the axo_mem bus. Copies len_i
//                32-bit words from src_i to dst_i using strictly alternating
//                read/write beats, then pulses done_o or err_o.
//  Revision    : 1.0  initial release
// ============================================================================
module axo_mem_copier
    import axo_copier_pkg::*;
#(
    parameter int ALEN     = 32,
    parameter int DLEN     = 32,
    parameter int LEN_BITS = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                start_i,
    input  wire logic [ALEN-1:0]     src_i,
    input  wire logic [ALEN-1:0]     dst_i,
    input  wire logic [LEN_BITS-1:0] len_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [31:0]              err_code_o,
    axo_mem_bus.master               bus
);

    localparam logic [ALEN-1:0]     c_WORD_BYTES = ALEN'(4);
    localparam logic [LEN_BITS-1:0] c_ONE        = LEN_BITS'(1);

    logic [2:0]          state_q,    state_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                err_q,      err_d;
    logic [31:0]         err_code_q, err_code_d;
    logic                re_q,       re_d;
    logic                we_q,       we_d;
    logic [ALEN-1:0]     addr_q,     addr_d;
    logic [DLEN-1:0]     wdata_q,    wdata_d;   // doubles as the 1-word buffer
    logic [ALEN-1:0]     cur_src_q,  cur_src_d;
    logic [ALEN-1:0]     cur_dst_q,  cur_dst_d;
    logic [LEN_BITS-1:0] rem_q,      rem_d;

    // Next-state logic: beat sequencing and output register values
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        re_d       = re_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cur_src_d  = cur_src_q;
        cur_dst_d  = cur_dst_q;
        rem_d      = rem_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_CHECK;
                    busy_d     = 1'b1;
                    err_code_d = AXO_MEM_OK;
                    cur_src_d  = src_i;
                    cur_dst_d  = dst_i;
                    rem_d      = len_i;
                end
            end

            S_CHECK: begin
                if ((cur_src_q[1:0] != 2'b00) || (cur_dst_q[1:0] != 2'b00)) begin
                    state_d    = S_ABORT;
                    err_code_d = AXO_MEM_EALIGN;
                end else if (rem_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_READ;
                    re_d    = 1'b1;
                    addr_d  = cur_src_q;
                end
            end

            S_READ: begin
                // Request is held unchanged until the responder completes it
                if (re_q && bus.ready) begin
                    re_d = 1'b0;
                    if (bus.error) begin
                        state_d    = S_ABORT;
                        err_code_d = 32'(bus.rdata);
                    end else begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        addr_d  = cur_dst_q;
                        wdata_d = bus.rdata;
                    end
                end
            end

            S_WRITE: begin
                if (we_q && bus.ready) begin
                    we_d = 1'b0;
                    if (bus.error) begin
                        state_d    = S_ABORT;
                        err_code_d = 32'(bus.rdata);
                    end else begin
                        cur_src_d = cur_src_q + c_WORD_BYTES;
                        cur_dst_d = cur_dst_q + c_WORD_BYTES;
                        rem_d     = rem_q - c_ONE;
                        if (rem_q == c_ONE) begin
                            state_d = S_FIN;
                        end else begin
                            // Next read issues back-to-back with no idle cycle
                            state_d = S_READ;
                            re_d    = 1'b1;
                            addr_d  = cur_src_q + c_WORD_BYTES;
                        end
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end

            S_ABORT: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                err_d   = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                re_d    = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cur_src_q  <= '0;
            cur_dst_q  <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            re_q       <= re_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cur_src_q  <= cur_src_d;
            cur_dst_q  <= cur_dst_d;
            rem_q      <= rem_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

    assign bus.re     = re_q;
    assign bus.we     = we_q;
    assign bus.asize  = C_ASIZE_WORD;
    assign bus.addr   = addr_q;
    assign bus.wdata  = wdata_q;

endmodule : axo_mem_copier
`default_nettype wire

// File: tb/tb_axo_mem_copier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axo_mem_copier
//  Description : Directed self-checking bench for axo_mem_copier with a
//                ROM (0x000-0x3FF, read-only) / RAM word responder that
//                decodes addr[11:2] and has a programmable ready delay.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axo_mem_copier;
    import axo_copier_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] src_i;
    logic [31:0] dst_i;
    logic [15:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] err_code_o;

    int passes = 0;
    int total  = 0;

    axo_mem_bus #(.ALEN(32), .DLEN(32)) bus ();

    axo_mem_copier #(.ALEN(32), .DLEN(32), .LEN_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .src_i      (src_i),
        .dst_i      (dst_i),
        .len_i      (len_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // ---------------- responder model ----------------
    logic [31:0] mem [0:1023];
    int          dly = 0;
    int          cnt = 0;
    logic [9:0]  w_idx;
    logic        w_rom;
    logic        pend = 1'b0;
    logic [31:0] p_addr;
    logic        p_we;
    logic [31:0] p_wdata;
    int          stab_err = 0;
    int          both_err = 0;
    int          active_cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] beat_addr [$];
    logic        beat_we   [$];

    assign w_idx     = bus.addr[11:2];
    assign w_rom     = (bus.addr < 32'h400);
    assign bus.ready = (bus.re || bus.we) && (cnt == dly);
    assign bus.error = bus.we && w_rom;
    assign bus.rdata = bus.error ? AXO_MEM_READONLY : mem[w_idx];

    always @(posedge clk) begin
        if (done_o) done_cnt++;
        if (err_o)  err_cnt++;
        if (bus.re && bus.we) both_err++;
        if (bus.re || bus.we) begin
            active_cyc++;
            if (pend && ((bus.addr !== p_addr) || (bus.we !== p_we) ||
                         (bus.we && (bus.wdata !== p_wdata))))
                stab_err++;
            if (bus.ready) begin
                beat_addr.push_back(bus.addr);
                beat_we.push_back(bus.we);
                if (bus.we && !bus.error) mem[w_idx] = bus.wdata;
                cnt  <= 0;
                pend <= 1'b0;
            end else begin
                cnt     <= cnt + 1;
                pend    <= 1'b1;
                p_addr  <= bus.addr;
                p_we    <= bus.we;
                p_wdata <= bus.wdata;
            end
        end else begin
            cnt  <= 0;
            pend <= 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_logs();
        beat_addr.delete();
        beat_we.delete();
        active_cyc = 0;
        stab_err   = 0;
        both_err   = 0;
    endtask

    // Starts a copy and returns edges from the accepting edge to done/err.
    // Also counts cycles in which busy was low before completion.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       output int cyc, output int busy_low);
        src_i   = s;
        dst_i   = d;
        len_i   = n;
        start_i = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        cyc      = 0;
        busy_low = 0;
        while (!done_o && !err_o && cyc < 2000) begin
            if (!busy_o) busy_low++;
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;
    int blow;
    int dc0;
    int ec0;

    initial begin
        for (int i = 0; i < 1024; i++)
            mem[i] = (i < 256) ? (32'hA000_0000 + 32'(i)) : 32'h0;
        rst     = 1'b1;
        start_i = 1'b0;
        src_i   = '0;
        dst_i   = '0;
        len_i   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",  {31'd0, busy_o}, 32'd0);
        check("rst_done",  {31'd0, done_o}, 32'd0);
        check("rst_err",   {31'd0, err_o},  32'd0);
        check("rst_code",  err_code_o,      32'd0);
        check("rst_re",    {31'd0, bus.re}, 32'd0);
        check("rst_we",    {31'd0, bus.we}, 32'd0);
        check("rst_asize", {30'd0, bus.asize}, 32'd2);
        check("rst_addr",  bus.addr,  32'd0);
        check("rst_wdata", bus.wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: zero-wait ROM 0 -> RAM 0x400, 4 words
        clear_logs();
        run(32'h0, 32'h400, 16'd4, cyc, blow);
        check("t1_latency", 32'(cyc), 32'd10);
        check("t1_done", {31'd0, done_o}, 32'd1);
        check("t1_busy_at_done", {31'd0, busy_o}, 32'd0);
        check("t1_beats", 32'(beat_addr.size()), 32'd8);
        for (int k = 0; k < 4; k++) begin
            check("t1_rd_addr", beat_addr[2*k],   32'(4*k));
            check("t1_rd_we",   {31'd0, beat_we[2*k]}, 32'd0);
            check("t1_wr_addr", beat_addr[2*k+1], 32'h400 + 32'(4*k));
            check("t1_wr_we",   {31'd0, beat_we[2*k+1]}, 32'd1);
            check("t1_data",    mem[10'h100 + 10'(k)], 32'hA000_0000 + 32'(k));
        end
        check("t1_both", 32'(both_err), 32'd0);
        @(negedge clk);
        check("t1_done_pulse", {31'd0, done_o}, 32'd0);

        // 2: 3-cycle ready delay
        dly = 3;
        clear_logs();
        run(32'h20, 32'h500, 16'd2, cyc, blow);
        check("t2_latency", 32'(cyc), 32'd18);
        check("t2_done", {31'd0, done_o}, 32'd1);
        check("t2_busy_low", 32'(blow), 32'd0);
        check("t2_stable", 32'(stab_err), 32'd0);
        check("t2_active", 32'(active_cyc), 32'd16);
        check("t2_data0", mem[10'h140], 32'hA000_0008);
        check("t2_data1", mem[10'h141], 32'hA000_0009);
        dly = 0;
        @(negedge clk);

        // 3a: misaligned source
        clear_logs();
        run(32'h2, 32'h400, 16'd3, cyc, blow);
        check("t3_err_latency", 32'(cyc), 32'd2);
        check("t3_err", {31'd0, err_o}, 32'd1);
        check("t3_code", err_code_o, AXO_MEM_EALIGN);
        check("t3_no_bus", 32'(active_cyc), 32'd0);
        @(negedge clk);
        check("t3_err_pulse", {31'd0, err_o}, 32'd0);

        // 3b: zero length
        clear_logs();
        run(32'h0, 32'h400, 16'd0, cyc, blow);
        check("t3b_latency", 32'(cyc), 32'd2);
        check("t3b_done", {31'd0, done_o}, 32'd1);
        check("t3b_no_bus", 32'(active_cyc), 32'd0);
        check("t3b_code_cleared", err_code_o, 32'd0);
        @(negedge clk);

        // 4: write into read-only ROM
        clear_logs();
        run(32'h0, 32'h10, 16'd2, cyc, blow);
        check("t4_latency", 32'(cyc), 32'd4);
        check("t4_err", {31'd0, err_o}, 32'd1);
        check("t4_done", {31'd0, done_o}, 32'd0);
        check("t4_code", err_code_o, AXO_MEM_READONLY);
        check("t4_beats", 32'(beat_addr.size()), 32'd2);
        check("t4_rom_kept", mem[4], 32'hA000_0004);
        @(negedge clk);
        @(negedge clk);
        check("t4_code_hold", err_code_o, AXO_MEM_READONLY);

        // 5: source wraps through 2^32
        mem[10'h3FE] = 32'hCAFE_0001;
        mem[10'h3FF] = 32'hCAFE_0002;
        clear_logs();
        run(32'hFFFF_FFF8, 32'h600, 16'd4, cyc, blow);
        check("t5_latency", 32'(cyc), 32'd10);
        check("t5_done", {31'd0, done_o}, 32'd1);
        check("t5_beats", 32'(beat_addr.size()), 32'd8);
        check("t5_rd0", beat_addr[0], 32'hFFFF_FFF8);
        check("t5_rd1", beat_addr[2], 32'hFFFF_FFFC);
        check("t5_rd2", beat_addr[4], 32'h0000_0000);
        check("t5_rd3", beat_addr[6], 32'h0000_0004);
        check("t5_d0", mem[10'h180], 32'hCAFE_0001);
        check("t5_d1", mem[10'h181], 32'hCAFE_0002);
        check("t5_d2", mem[10'h182], 32'hA000_0000);
        check("t5_d3", mem[10'h183], 32'hA000_0001);
        @(negedge clk);

        // 6: restart attempt while busy, then reset mid-WRITE of word 1
        clear_logs();
        src_i   = 32'h40;
        dst_i   = 32'h700;
        len_i   = 16'd4;
        start_i = 1'b1;
        @(negedge clk);                  // accepted; CHECK
        start_i = 1'b0;
        @(negedge clk);                  // READ word 0
        start_i = 1'b1;
        src_i   = 32'h80;
        dst_i   = 32'h7F0;
        len_i   = 16'd1;
        @(negedge clk);                  // WRITE word 0
        start_i = 1'b0;
        @(negedge clk);                  // READ word 1
        @(negedge clk);                  // WRITE word 1
        check("t6_we",    {31'd0, bus.we}, 32'd1);
        check("t6_addr",  bus.addr,  32'h704);
        check("t6_wdata", bus.wdata, 32'hA000_0011);
        check("t6_busy",  {31'd0, busy_o}, 32'd1);
        dc0 = done_cnt;
        ec0 = err_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_re",   {31'd0, bus.re}, 32'd0);
        check("t6_rst_we",   {31'd0, bus.we}, 32'd0);
        check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        check("t6_rst_addr", bus.addr,  32'd0);
        check("t6_rst_wdata", bus.wdata, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_no_done", 32'(done_cnt - dc0), 32'd0);
        check("t6_no_err",  32'(err_cnt - ec0),  32'd0);
        check("t6_idle_re", {31'd0, bus.re}, 32'd0);
        check("t6_idle_busy", {31'd0, busy_o}, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule : tb_axo_mem_copier
`default_nettype wire
